sdram_arbiter: RTL and testbench
================================

# sdram_arbiter

Shares the single 8-bit SDRAM port among three requesters: the ROM/file download path, the video fetch path and the CPU path of the VTL chip. It replaces the fixed download-versus-chip multiplexer in front of the `sdram` controller. It runs one access at a time in fixed-length slots, uses fixed priority with a CPU starvation guard, and returns read data and a one-cycle acknowledge to the winning requester.

## Interface
Parameters:
- `SLOT_LEN`, default 2: F14M cycles that the command is held on the SDRAM port per access. Must be at least 1.
- `MAX_VID`, default 4: number of consecutive video grants allowed while a CPU request waits.

Ports:
- `F14M`  in  1  system clock; all state updates on its rising edge.
- `RESET_n`  in  1  asynchronous, active-low reset.
- `dio_active`  in  1  download in progress; while high only the download requester is granted.
- `dio_req`, `vid_req`, `cpu_req`  in  1 each  level request; held until the matching ack.
- `dio_we`, `vid_we`, `cpu_we`  in  1 each  1 = write, 0 = read; stable while req is high.
- `dio_addr`, `vid_addr`, `cpu_addr`  in  25 each  byte address.
- `dio_din`, `vid_din`, `cpu_din`  in  8 each  write data.
- `dio_ack`, `vid_ack`, `cpu_ack`  out  1 each  one-cycle completion pulse.
- `vid_dout`, `cpu_dout`  out  8 each  read data register; updated only by that requester's reads.
- `sd_addr`  out  25  address to the SDRAM controller.
- `sd_din`  out  8  write data to the SDRAM controller.
- `sd_we`, `sd_oe`  out  1 each  write strobe and read strobe to the SDRAM controller.
- `sd_dout`  in  8  read data from the SDRAM controller.

## Operation
- The state machine has three states: IDLE, BUSY and DONE. The slot counter `cnt` is ceil(log2(SLOT_LEN+1)) bits wide.
- **IDLE.** Requests are sampled here only. A winner is chosen as follows:
  - `dio_active`=1: grant `dio_req` if it is high. Otherwise nothing is granted, and video and CPU requests stay pending.
  - `dio_active`=0: priority order is video, then CPU, then download.
  - Starvation guard: if `cpu_req`=1 and `vidrun`==MAX_VID, the CPU wins over video.
- On a grant, the arbiter latches the winner ID and that requester's addr, din and we into the port registers. It then sets `cnt`=SLOT_LEN-1 and moves to BUSY.
- **BUSY.** During this state:
  - `sd_addr` and `sd_din` hold the latched values.
  - `sd_we` = latched we.
  - `sd_oe` = ~latched we.
  - `cnt` decrements each cycle.
  - At `cnt`==0 the arbiter moves to DONE. On that same edge, if the access is a read, `sd_dout` is captured into the winner's dout register. The download requester has no dout.
- **DONE.** `sd_we` and `sd_oe` are 0, and the winner's ack is 1 for exactly this cycle. The next state is IDLE.
- **`vidrun` (3-bit counter).**
  - Increments, saturating at MAX_VID, on a video grant made while `cpu_req`=1.
  - Clears on a CPU grant.
  - Clears on a video grant made while `cpu_req`=0.
- Boundary rules:
  - If a requester drops req during BUSY, the access still completes and its ack still pulses.
  - If `dio_active` falls during a download access, that access completes normally.
  - A requester must deassert req, or present a new request, on the edge where its ack is seen. A req still high in the IDLE cycle that follows DONE is treated as a new request.
  - At most one ack is high in any cycle. Acks are never issued in IDLE or BUSY.
- **Reset (async, mid-operation included).** The state machine returns to IDLE and `vidrun` is cleared. All outputs go to 0 immediately: every ack, every dout, `sd_addr`, `sd_din`, `sd_we` and `sd_oe`. An aborted write may partially complete in SDRAM, and the system tolerates this.

## Timing
- Outputs are registered only; there are no combinational paths from inputs to outputs.
- With req high in IDLE cycle n:
  - The SDRAM command is driven in cycles n+1 through n+SLOT_LEN.
  - The ack is high in cycle n+SLOT_LEN+1.
  - dout is valid from cycle n+SLOT_LEN+1 onward.
- The earliest next grant is made in IDLE at cycle n+SLOT_LEN+2. Peak throughput is therefore one access per SLOT_LEN+2 cycles, which is 4 at the default.

## Test plan
- **Reset values.** Assert RESET_n=0 in the middle of BUSY with a write in progress → `sd_we`, all acks and all douts read 0 in the same cycle, and after release the state is IDLE.
- **Single CPU read.** Hold `cpu_req`=1, `cpu_we`=0, `cpu_addr`=0x0001234, with the model returning `sd_dout`=0xA5 → `sd_oe`=1 for exactly 2 cycles, `cpu_ack` pulses 3 cycles after the grant edge, `cpu_dout`=0xA5, and `vid_dout` is unchanged.
- **Priority and starvation.** Hold `vid_req` and `cpu_req` continuously (each requester re-requests after its ack) → grant sequence is V,V,V,V,C,V,V,V,V,C.
- **Download gating.** With `dio_active`=1, hold `vid_req`, `cpu_req` and `dio_req` (write 0x3C to 0x0000010) → only `dio_ack` pulses and `sd_we`=1 for 2 cycles. When `dio_active` drops, the video request is granted on the next IDLE.
- **Write path.** Issue a CPU write of 0x5A to 0x1FFFFFF → `sd_addr`=0x1FFFFFF, `sd_din`=0x5A, `sd_we`=1 and `sd_oe`=0 during BUSY, and `cpu_dout` is unchanged.
- **Early req drop.** Deassert `vid_req` in the first BUSY cycle → `vid_ack` still pulses once, and no further video access is granted.

Source files
------------

// File: rtl/sdram_arbiter.sv
// Shares the 8-bit SDRAM port among the download, video and CPU requesters.
// One access at a time in fixed slots: fixed priority plus a CPU starvation guard.
module sdram_arbiter #(
    parameter int SLOT_LEN = 2,
    parameter int MAX_VID  = 4
) (
    input  logic        F14M,
    input  logic        RESET_n,
    input  logic        dio_active,
    input  logic        dio_req,
    input  logic        vid_req,
    input  logic        cpu_req,
    input  logic        dio_we,
    input  logic        vid_we,
    input  logic        cpu_we,
    input  logic [24:0] dio_addr,
    input  logic [24:0] vid_addr,
    input  logic [24:0] cpu_addr,
    input  logic [7:0]  dio_din,
    input  logic [7:0]  vid_din,
    input  logic [7:0]  cpu_din,
    output logic        dio_ack,
    output logic        vid_ack,
    output logic        cpu_ack,
    output logic [7:0]  vid_dout,
    output logic [7:0]  cpu_dout,
    output logic [24:0] sd_addr,
    output logic [7:0]  sd_din,
    output logic        sd_we,
    output logic        sd_oe,
    input  logic [7:0]  sd_dout
);

    localparam int CNT_W = $clog2(SLOT_LEN + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic [1:0] {SRC_DIO, SRC_VID, SRC_CPU} src_t;

    state_t             state, state_nxt;
    src_t               win, grant_src;
    logic               grant;
    logic [24:0]        grant_addr;
    logic [7:0]         grant_din;
    logic               grant_we;
    logic               lat_we;
    logic [CNT_W-1:0]   cnt;
    logic [2:0]         vidrun;
    logic               vid_starved;

    assign vid_starved = cpu_req && (vidrun == 3'(MAX_VID));

    // Winner selection happens only in IDLE; a download in progress locks out the chip.
    always_comb begin
        grant      = 1'b0;
        grant_src  = SRC_DIO;
        grant_addr = dio_addr;
        grant_din  = dio_din;
        grant_we   = dio_we;
        if (state == IDLE) begin
            if (dio_active) begin
                grant = dio_req;
            end else if (vid_req && !vid_starved) begin
                grant     = 1'b1;
                grant_src = SRC_VID;
            end else if (cpu_req) begin
                grant     = 1'b1;
                grant_src = SRC_CPU;
            end else begin
                grant = dio_req;
            end
        end
        case (grant_src)
            SRC_VID: begin
                grant_addr = vid_addr;
                grant_din  = vid_din;
                grant_we   = vid_we;
            end
            SRC_CPU: begin
                grant_addr = cpu_addr;
                grant_din  = cpu_din;
                grant_we   = cpu_we;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant) state_nxt = BUSY;
            BUSY:    if (cnt == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge F14M or negedge RESET_n) begin
        if (!RESET_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Port registers, slot counter, read capture and the single-cycle acks.
    always_ff @(posedge F14M or negedge RESET_n) begin
        if (!RESET_n) begin
            win      <= SRC_DIO;
            lat_we   <= 1'b0;
            cnt      <= '0;
            vidrun   <= 3'd0;
            sd_addr  <= 25'd0;
            sd_din   <= 8'd0;
            sd_we    <= 1'b0;
            sd_oe    <= 1'b0;
            dio_ack  <= 1'b0;
            vid_ack  <= 1'b0;
            cpu_ack  <= 1'b0;
            vid_dout <= 8'd0;
            cpu_dout <= 8'd0;
        end else begin
            dio_ack <= 1'b0;
            vid_ack <= 1'b0;
            cpu_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant) begin
                        win     <= grant_src;
                        lat_we  <= grant_we;
                        sd_addr <= grant_addr;
                        sd_din  <= grant_din;
                        sd_we   <= grant_we;
                        sd_oe   <= ~grant_we;
                        cnt     <= CNT_W'(SLOT_LEN - 1);
                        if (grant_src == SRC_CPU) begin
                            vidrun <= 3'd0;
                        end else if (grant_src == SRC_VID) begin
                            if (!cpu_req)                   vidrun <= 3'd0;
                            else if (vidrun != 3'(MAX_VID)) vidrun <= vidrun + 3'd1;
                        end
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        sd_we <= 1'b0;
                        sd_oe <= 1'b0;
                        case (win)
                            SRC_VID: begin
                                vid_ack <= 1'b1;
                                if (!lat_we) vid_dout <= sd_dout;
                            end
                            SRC_CPU: begin
                                cpu_ack <= 1'b1;
                                if (!lat_we) cpu_dout <= sd_dout;
                            end
                            default: dio_ack <= 1'b1;
                        endcase
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: reset, read/write paths, priority, gating, early drop.
module tb_sdram_arbiter;

    logic        F14M = 1'b0;
    logic        RESET_n;
    logic        dio_active, dio_req, vid_req, cpu_req;
    logic        dio_we, vid_we, cpu_we;
    logic [24:0] dio_addr, vid_addr, cpu_addr;
    logic [7:0]  dio_din, vid_din, cpu_din;
    logic        dio_ack, vid_ack, cpu_ack;
    logic [7:0]  vid_dout, cpu_dout;
    logic [24:0] sd_addr;
    logic [7:0]  sd_din;
    logic        sd_we, sd_oe;
    logic [7:0]  sd_dout;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 F14M = ~F14M;

    sdram_arbiter dut (
        .F14M(F14M), .RESET_n(RESET_n), .dio_active(dio_active),
        .dio_req(dio_req), .vid_req(vid_req), .cpu_req(cpu_req),
        .dio_we(dio_we), .vid_we(vid_we), .cpu_we(cpu_we),
        .dio_addr(dio_addr), .vid_addr(vid_addr), .cpu_addr(cpu_addr),
        .dio_din(dio_din), .vid_din(vid_din), .cpu_din(cpu_din),
        .dio_ack(dio_ack), .vid_ack(vid_ack), .cpu_ack(cpu_ack),
        .vid_dout(vid_dout), .cpu_dout(cpu_dout),
        .sd_addr(sd_addr), .sd_din(sd_din), .sd_we(sd_we), .sd_oe(sd_oe),
        .sd_dout(sd_dout)
    );

    task automatic do_reset();
        RESET_n    = 1'b0;
        dio_active = 1'b0;
        dio_req = 1'b0; vid_req = 1'b0; cpu_req = 1'b0;
        dio_we  = 1'b0; vid_we  = 1'b0; cpu_we  = 1'b0;
        dio_addr = '0; vid_addr = '0; cpu_addr = '0;
        dio_din = '0; vid_din = '0; cpu_din = '0;
        sd_dout = '0;
        repeat (2) @(negedge F14M);
        RESET_n = 1'b1;
        @(negedge F14M);
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if ({dio_ack, vid_ack, cpu_ack, sd_we, sd_oe} !== 5'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_ctrl: got %b required 00000", {dio_ack, vid_ack, cpu_ack, sd_we, sd_oe});
        end
        tests_run++;
        if ({sd_addr, sd_din, vid_dout, cpu_dout} !== 49'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_data: got %h required 0", {sd_addr, sd_din, vid_dout, cpu_dout});
        end
    endtask

    task automatic test_cpu_read();
        int oe_cycles = 0;
        int ack_cycle = -1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 25'h0001234; sd_dout = 8'hA5;
        for (int c = 1; c <= 6; c++) begin
            @(negedge F14M);
            if (sd_oe) oe_cycles++;
            if (cpu_ack && ack_cycle < 0) ack_cycle = c;
            if (c == 1) begin
                tests_run++;
                if (sd_addr !== 25'h0001234) begin
                    tests_failed++;
                    $display("[TB] FAIL read_addr: got %h required 0001234", sd_addr);
                end
            end
            if (cpu_ack) cpu_req = 1'b0;
        end
        tests_run++;
        if (oe_cycles !== 2) begin
            tests_failed++;
            $display("[TB] FAIL read_oe_len: got %0d required 2", oe_cycles);
        end
        tests_run++;
        if (ack_cycle !== 3) begin
            tests_failed++;
            $display("[TB] FAIL read_ack_cycle: got %0d required 3", ack_cycle);
        end
        tests_run++;
        if (cpu_dout !== 8'hA5) begin
            tests_failed++;
            $display("[TB] FAIL read_cpu_dout: got %h required a5", cpu_dout);
        end
        tests_run++;
        if (vid_dout !== 8'h00) begin
            tests_failed++;
            $display("[TB] FAIL read_vid_dout: got %h required 00", vid_dout);
        end
    endtask

    task automatic test_write_path();
        int bad = 0;
        int acks = 0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 25'h1FFFFFF; cpu_din = 8'h5A; sd_dout = 8'h77;
        for (int c = 1; c <= 5; c++) begin
            @(negedge F14M);
            if (c <= 2 && (sd_addr !== 25'h1FFFFFF || sd_din !== 8'h5A || sd_we !== 1'b1 || sd_oe !== 1'b0))
                bad++;
            if (cpu_ack) begin
                acks++;
                cpu_req = 1'b0;
            end
        end
        cpu_we = 1'b0;
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("[TB] FAIL write_busy: got %0d bad cycles required 0", bad);
        end
        tests_run++;
        if (acks !== 1) begin
            tests_failed++;
            $display("[TB] FAIL write_ack: got %0d acks required 1", acks);
        end
        tests_run++;
        if (cpu_dout !== 8'hA5) begin
            tests_failed++;
            $display("[TB] FAIL write_cpu_dout: got %h required a5", cpu_dout);
        end
    endtask

    task automatic test_priority();
        byte seq [10];
        byte exp_seq [10];
        int  n = 0;
        int  multi = 0;
        exp_seq = '{"V", "V", "V", "V", "C", "V", "V", "V", "V", "C"};
        do_reset();
        vid_req = 1'b1; cpu_req = 1'b1; sd_dout = 8'h99;
        for (int c = 0; c < 200 && n < 10; c++) begin
            @(negedge F14M);
            if (int'(dio_ack) + int'(vid_ack) + int'(cpu_ack) > 1) multi++;
            if (vid_ack) begin seq[n] = "V"; n++; end
            else if (cpu_ack) begin seq[n] = "C"; n++; end
        end
        vid_req = 1'b0; cpu_req = 1'b0;
        tests_run++;
        if (n !== 10) begin
            tests_failed++;
            $display("[TB] FAIL prio_count: got %0d grants required 10", n);
        end
        for (int i = 0; i < n; i++) begin
            tests_run++;
            if (seq[i] !== exp_seq[i]) begin
                tests_failed++;
                $display("[TB] FAIL prio_seq[%0d]: got %c required %c", i, seq[i], exp_seq[i]);
            end
        end
        tests_run++;
        if (multi !== 0) begin
            tests_failed++;
            $display("[TB] FAIL prio_onehot: got %0d multi-ack cycles required 0", multi);
        end
        repeat (3) @(negedge F14M);
    endtask

    task automatic test_dio_gating();
        int we_cycles = 0;
        int dio_acks = 0;
        int other_acks = 0;
        int vid_ok = 0;
        int done_c = -1;
        dio_active = 1'b1;
        vid_req = 1'b1; cpu_req = 1'b1; dio_req = 1'b1;
        dio_we = 1'b1; dio_addr = 25'h0000010; dio_din = 8'h3C; vid_addr = 25'h0000ABC;
        for (int c = 1; c <= 12; c++) begin
            @(negedge F14M);
            if (done_c < 0) begin
                if (sd_we && sd_addr === 25'h0000010 && sd_din === 8'h3C) we_cycles++;
                if (vid_ack || cpu_ack) other_acks++;
                if (dio_ack) begin
                    dio_acks++;
                    done_c = c;
                    dio_req = 1'b0; dio_active = 1'b0; cpu_req = 1'b0;
                end
            end else if (c == done_c + 2) begin
                if (sd_oe && sd_addr === 25'h0000ABC) vid_ok = 1;
            end
            if (vid_ack) vid_req = 1'b0;
        end
        tests_run++;
        if (we_cycles !== 2) begin
            tests_failed++;
            $display("[TB] FAIL dio_we_len: got %0d required 2", we_cycles);
        end
        tests_run++;
        if (dio_acks !== 1 || other_acks !== 0) begin
            tests_failed++;
            $display("[TB] FAIL dio_only_ack: got dio=%0d other=%0d required 1/0", dio_acks, other_acks);
        end
        tests_run++;
        if (vid_ok !== 1) begin
            tests_failed++;
            $display("[TB] FAIL dio_then_vid: got %0d required 1", vid_ok);
        end
        dio_we = 1'b0;
        repeat (3) @(negedge F14M);
    endtask

    task automatic test_early_drop();
        int acks = 0;
        int oe_cycles = 0;
        vid_req = 1'b1; vid_we = 1'b0; vid_addr = 25'h0000555; sd_dout = 8'h66;
        for (int c = 1; c <= 10; c++) begin
            @(negedge F14M);
            if (c == 1) vid_req = 1'b0;
            if (sd_oe) oe_cycles++;
            if (vid_ack) acks++;
        end
        tests_run++;
        if (acks !== 1) begin
            tests_failed++;
            $display("[TB] FAIL drop_ack: got %0d required 1", acks);
        end
        tests_run++;
        if (oe_cycles !== 2) begin
            tests_failed++;
            $display("[TB] FAIL drop_oe_len: got %0d required 2", oe_cycles);
        end
        tests_run++;
        if (vid_dout !== 8'h66) begin
            tests_failed++;
            $display("[TB] FAIL drop_vid_dout: got %h required 66", vid_dout);
        end
    endtask

    task automatic test_reset_mid_busy();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 25'h0000042; cpu_din = 8'hC3;
        @(negedge F14M);
        tests_run++;
        if (sd_we !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL midrst_pre_we: got %b required 1", sd_we);
        end
        RESET_n = 1'b0;
        #1;
        tests_run++;
        if ({sd_we, sd_oe, dio_ack, vid_ack, cpu_ack} !== 5'b0) begin
            tests_failed++;
            $display("[TB] FAIL midrst_ctrl: got %b required 00000", {sd_we, sd_oe, dio_ack, vid_ack, cpu_ack});
        end
        tests_run++;
        if ({sd_addr, sd_din, vid_dout, cpu_dout} !== 49'd0) begin
            tests_failed++;
            $display("[TB] FAIL midrst_data: got %h required 0", {sd_addr, sd_din, vid_dout, cpu_dout});
        end
        cpu_req = 1'b0; cpu_we = 1'b0;
        @(negedge F14M);
        RESET_n = 1'b1;
        @(negedge F14M);
        cpu_req = 1'b1;
        @(negedge F14M);
        tests_run++;
        if (sd_oe !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL midrst_idle_after: got sd_oe=%b required 1", sd_oe);
        end
        cpu_req = 1'b0;
        repeat (4) @(negedge F14M);
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_write_path();
        test_priority();
        test_dio_gating();
        test_early_drop();
        test_reset_mid_busy();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
